// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA types and default 640x480@60 timing, used by the generator RTL and its bench.
package VGA_item_pack;

  localparam int unsigned COLOR_WIDTH = 4;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef struct packed {
    logic [COLOR_WIDTH-1:0] red;
    logic [COLOR_WIDTH-1:0] green;
    logic [COLOR_WIDTH-1:0] blue;
  } rgb_t;

  typedef enum logic [1:0] {
    PhActive,
    PhFront,
    PhSync,
    PhBack
  } phase_e;

  // Bar k lights the channels selected by its index bits, R on bit 2.
  function automatic rgb_t bar_colour(input logic [2:0] k);
    rgb_t c;
    c.red   = {COLOR_WIDTH{k[2]}};
    c.green = {COLOR_WIDTH{k[1]}};
    c.blue  = {COLOR_WIDTH{k[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Free-running horizontal/vertical position counters with per-axis blanking phase decode.
module vga_sync_counter
  import VGA_item_pack::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HCW     = $clog2(H_TOTAL),
  localparam int unsigned VCW     = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic [HCW-1:0] h_cnt_o,
  output phase_e         h_phase_o,
  output phase_e         v_phase_o
);

  localparam logic [HCW-1:0] HLast      = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] HFrontBeg  = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HSyncBeg   = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HBackBeg   = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW-1:0] VLast      = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] VFrontBeg  = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VSyncBeg   = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VBackBeg   = VCW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HCW-1:0] h_cnt_q, h_cnt_d;
  logic [VCW-1:0] v_cnt_q, v_cnt_d;
  logic           h_wrap;

  always_comb begin
    h_wrap  = (h_cnt_q == HLast);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    if (h_cnt_q < HFrontBeg) begin
      h_phase_o = PhActive;
    end else if (h_cnt_q < HSyncBeg) begin
      h_phase_o = PhFront;
    end else if (h_cnt_q < HBackBeg) begin
      h_phase_o = PhSync;
    end else begin
      h_phase_o = PhBack;
    end
  end

  always_comb begin
    if (v_cnt_q < VFrontBeg) begin
      v_phase_o = PhActive;
    end else if (v_cnt_q < VSyncBeg) begin
      v_phase_o = PhFront;
    end else if (v_cnt_q < VBackBeg) begin
      v_phase_o = PhSync;
    end else begin
      v_phase_o = PhBack;
    end
  end

  assign h_cnt_o = h_cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: sync counters, upstream pixel handshake and registered sync/RGB outputs.
// Define VGA_TEST_PATTERN_EN to add the pattern_en input and the 8-bar colour test pattern.
module vga_timing_gen
  import VGA_item_pack::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                     pattern_en,
`endif
  input  logic                     pix_valid,
  input  logic [3*COLOR_WIDTH-1:0] pix_data,
  output logic                     pix_ready,
  output logic                     HSync,
  output logic                     VSync,
  output logic [COLOR_WIDTH-1:0]   Red,
  output logic [COLOR_WIDTH-1:0]   Green,
  output logic [COLOR_WIDTH-1:0]   Blue,
  output logic                     underflow
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned HCW     = $clog2(H_TOTAL);

  logic [HCW-1:0] h_cnt;
  phase_e         h_phase;
  phase_e         v_phase;
  logic           active;
  logic           pattern_on;
  rgb_t           bar_rgb;

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic underflow_q, underflow_d;
  rgb_t rgb_q, rgb_d;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .h_cnt_o   (h_cnt),
    .h_phase_o (h_phase),
    .v_phase_o (v_phase)
  );

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BarW = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [2:0] bar_idx;

  assign bar_idx    = 3'(h_cnt / HCW'(BarW));
  assign bar_rgb    = bar_colour(bar_idx);
  assign pattern_on = pattern_en;
`else
  logic unused_h_cnt;

  assign unused_h_cnt = ^h_cnt;
  assign bar_rgb      = '0;
  assign pattern_on   = 1'b0;
`endif

  assign active = (h_phase == PhActive) && (v_phase == PhActive);

  // Gated by rst_n so the handshake is closed for the whole reset, not only after the first edge.
  assign pix_ready = rst_n && active && !pattern_on;

  always_comb begin
    hsync_d     = (h_phase != PhSync);
    vsync_d     = (v_phase != PhSync);
    rgb_d       = '0;
    underflow_d = 1'b0;
    if (active && pattern_on) begin
      rgb_d = bar_rgb;
    end else if (pix_ready) begin
      // A missing pixel is blanked and flagged; timing never waits for upstream.
      if (pix_valid) begin
        rgb_d = rgb_t'(pix_data);
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
    end
  end

  assign HSync     = hsync_q;
  assign VSync     = vsync_q;
  assign Red       = rgb_q.red;
  assign Green     = rgb_q.green;
  assign Blue      = rgb_q.blue;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a 640x480 instance for line timing and a small-geometry
// instance so whole-frame and mid-frame reset behaviour fit in a short run.
module tb_vga_timing_gen;
  import VGA_item_pack::*;

  localparam int DW  = 3 * COLOR_WIDTH;
  localparam int HT  = 800;
  localparam int VT  = 525;
  localparam int SHT = 25;
  localparam int SVT = 19;
  localparam int SFT = SHT * SVT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n = 1'b0;
  logic                   rst_s_n = 1'b0;
  logic                   pix_valid = 1'b1;
  logic                   pix_valid_s = 1'b1;
  logic [DW-1:0]          pix_data = '0;
  logic [DW-1:0]          pix_data_s = '0;
  logic                   pix_ready, hsync, vsync, underflow;
  logic                   pix_ready_s, hsync_s, vsync_s, underflow_s;
  logic [COLOR_WIDTH-1:0] red, green, blue, red_s, green_s, blue_s;
`ifdef VGA_TEST_PATTERN_EN
  logic                   pattern_en = 1'b0;
`endif

  int          vec = 0;
  int          err = 0;
  int          pos = 0;
  int          pos_s = 0;
  int unsigned pcnt = 0;
  int unsigned pcnt_s = 0;

  vga_timing_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_en(pattern_en),
`endif
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .HSync     (hsync),
    .VSync     (vsync),
    .Red       (red),
    .Green     (green),
    .Blue      (blue),
    .underflow (underflow)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_s (
    .clk       (clk),
    .rst_n     (rst_s_n),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_en(1'b0),
`endif
    .pix_valid (pix_valid_s),
    .pix_data  (pix_data_s),
    .pix_ready (pix_ready_s),
    .HSync     (hsync_s),
    .VSync     (vsync_s),
    .Red       (red_s),
    .Green     (green_s),
    .Blue      (blue_s),
    .underflow (underflow_s)
  );

  function automatic logic [DW-1:0] bar_exp(input int hc);
    int k;
    logic [COLOR_WIDTH-1:0] mx, c_r, c_g, c_b;
    k   = hc / 80;
    mx  = '1;
    c_r = k[2] ? mx : '0;
    c_g = k[1] ? mx : '0;
    c_b = k[0] ? mx : '0;
    return {c_r, c_g, c_b};
  endfunction

  // One pixel clock on the 640x480 instance; returns model expectations for the sampled outputs.
  task automatic step_d(input bit valid, input bit pat, output bit rdy, output bit exp_rdy,
                        output logic [DW-1:0] exp_rgb, output bit exp_hs, output bit exp_vs,
                        output bit exp_uf);
    int hc, vc;
    bit act;
    if (clk) @(negedge clk);
    hc = pos % HT;
    vc = (pos / HT) % VT;
    act = (hc < 640) && (vc < 480);
    pix_valid = valid;
    pix_data  = pcnt[DW-1:0];
`ifdef VGA_TEST_PATTERN_EN
    pattern_en = pat;
`endif
    #1 rdy = pix_ready;
    @(posedge clk);
    #1;
    exp_rdy = act && !pat;
    exp_hs  = !(hc >= 656 && hc < 752);
    exp_vs  = !(vc >= 490 && vc < 492);
    exp_rgb = '0;
    exp_uf  = 1'b0;
    if (act && pat) begin
      exp_rgb = bar_exp(hc);
    end else if (act && valid) begin
      exp_rgb = pcnt[DW-1:0];
      pcnt++;
    end else if (act) begin
      exp_uf = 1'b1;
    end
    pos++;
  endtask

  // Same for the small instance: 16+2+4+3 pixels, 12+2+2+3 lines.
  task automatic step_s(input bit valid, output bit rdy, output bit exp_rdy,
                        output logic [DW-1:0] exp_rgb, output bit exp_hs, output bit exp_vs,
                        output bit exp_uf);
    int hc, vc;
    bit act;
    if (clk) @(negedge clk);
    hc = pos_s % SHT;
    vc = (pos_s / SHT) % SVT;
    act = (hc < 16) && (vc < 12);
    pix_valid_s = valid;
    pix_data_s  = pcnt_s[DW-1:0];
    #1 rdy = pix_ready_s;
    @(posedge clk);
    #1;
    exp_rdy = act;
    exp_hs  = !(hc >= 18 && hc < 22);
    exp_vs  = !(vc >= 14 && vc < 16);
    exp_rgb = '0;
    exp_uf  = 1'b0;
    if (act && valid) begin
      exp_rgb = pcnt_s[DW-1:0];
      pcnt_s++;
    end else if (act) begin
      exp_uf = 1'b1;
    end
    pos_s++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vec++; if (hsync !== 1'b1 || vsync !== 1'b1) begin err++;
      $display("FAIL reset_sync: got hs=%b vs=%b want 1 1", hsync, vsync); end
    vec++; if ({red, green, blue} !== '0) begin err++;
      $display("FAIL reset_rgb: got %h want 0", {red, green, blue}); end
    vec++; if (underflow !== 1'b0 || pix_ready !== 1'b0) begin err++;
      $display("FAIL reset_uf_rdy: got uf=%b rdy=%b want 0 0", underflow, pix_ready); end
    vec++; if (hsync_s !== 1'b1 || vsync_s !== 1'b1 || {red_s, green_s, blue_s} !== '0 ||
               pix_ready_s !== 1'b0 || underflow_s !== 1'b0) begin err++;
      $display("FAIL reset_small: got hs=%b vs=%b rgb=%h rdy=%b uf=%b want 1 1 0 0 0",
               hsync_s, vsync_s, {red_s, green_s, blue_s}, pix_ready_s, underflow_s); end
    @(negedge clk);
    rst_n = 1'b1;
    pos   = 0;
    pcnt  = 0;
    #1;
    vec++; if (pix_ready !== 1'b1) begin err++;
      $display("FAIL release_ready: got %b want 1", pix_ready); end
  endtask

  task automatic test_hsync_timing();
    bit rdy, er, ehs, evs, euf;
    logic [DW-1:0] ergb;
    logic prev = 1'b1;
    int fall1 = -1, fall2 = -1, rise1 = -1, acc0 = 0, acc1 = 0, line;
    for (int c = 1; c <= 2 * HT; c++) begin
      line = pos / HT;
      step_d(1'b1, 1'b0, rdy, er, ergb, ehs, evs, euf);
      if (rdy === 1'b1) begin
        if (line == 0) acc0++; else acc1++;
      end
      vec++; if (rdy !== er) begin err++;
        $display("FAIL line_ready c=%0d: got %b want %b", c, rdy, er); end
      vec++; if (hsync !== ehs || vsync !== evs) begin err++;
        $display("FAIL line_sync c=%0d: got %b%b want %b%b", c, hsync, vsync, ehs, evs); end
      vec++; if ({red, green, blue} !== ergb || underflow !== euf) begin err++;
        $display("FAIL line_pixel c=%0d: got %h/%b want %h/%b", c, {red, green, blue},
                 underflow, ergb, euf); end
      if (prev === 1'b1 && hsync === 1'b0) begin
        if (fall1 < 0) fall1 = c; else if (fall2 < 0) fall2 = c;
      end
      if (prev === 1'b0 && hsync === 1'b1 && rise1 < 0) rise1 = c;
      prev = hsync;
    end
    vec++; if (fall1 != 657) begin err++;
      $display("FAIL hsync_first_fall: got %0d want 657", fall1); end
    vec++; if (rise1 - fall1 != 96) begin err++;
      $display("FAIL hsync_width: got %0d want 96", rise1 - fall1); end
    vec++; if (fall2 - fall1 != 800) begin err++;
      $display("FAIL hsync_period: got %0d want 800", fall2 - fall1); end
    vec++; if (acc0 != 640 || acc1 != 640) begin err++;
      $display("FAIL pixels_per_line: got %0d,%0d want 640,640", acc0, acc1); end
  endtask

  task automatic test_underflow();
    bit rdy, er, ehs, evs, euf, valid;
    logic [DW-1:0] ergb;
    int pulses = 0, hc;
    for (int c = 0; c < HT; c++) begin
      hc = pos % HT;
      valid = !(hc >= 100 && hc <= 104);
      step_d(valid, 1'b0, rdy, er, ergb, ehs, evs, euf);
      if (underflow === 1'b1) pulses++;
      vec++; if (rdy !== er) begin err++;
        $display("FAIL uf_ready hc=%0d: got %b want %b", hc, rdy, er); end
      vec++; if (hsync !== ehs || vsync !== evs) begin err++;
        $display("FAIL uf_sync hc=%0d: got %b%b want %b%b", hc, hsync, vsync, ehs, evs); end
      vec++; if ({red, green, blue} !== ergb || underflow !== euf) begin err++;
        $display("FAIL uf_pixel hc=%0d: got %h/%b want %h/%b", hc, {red, green, blue},
                 underflow, ergb, euf); end
    end
    vec++; if (pulses != 5) begin err++;
      $display("FAIL uf_pulse_count: got %0d want 5", pulses); end
  endtask

  task automatic test_frame_small();
    bit rdy, er, ehs, evs, euf;
    logic [DW-1:0] ergb;
    logic prev_h = 1'b1, prev_v = 1'b1;
    int hfall = -1, vfall1 = -1, vfall2 = -1, vrise = -1, acc_f = 0, acc_l = 0, p;
    @(negedge clk);
    rst_s_n = 1'b1;
    pos_s   = 0;
    pcnt_s  = 0;
    for (int c = 1; c <= 2 * SFT + 50; c++) begin
      p = pos_s;
      step_s(1'b1, rdy, er, ergb, ehs, evs, euf);
      if (rdy === 1'b1 && p < SFT) acc_f++;
      if (rdy === 1'b1 && p < SHT) acc_l++;
      vec++; if (rdy !== er) begin err++;
        $display("FAIL frame_ready c=%0d: got %b want %b", c, rdy, er); end
      vec++; if (hsync_s !== ehs || vsync_s !== evs) begin err++;
        $display("FAIL frame_sync c=%0d: got %b%b want %b%b", c, hsync_s, vsync_s, ehs, evs); end
      vec++; if ({red_s, green_s, blue_s} !== ergb || underflow_s !== euf) begin err++;
        $display("FAIL frame_pixel c=%0d: got %h/%b want %h/%b", c, {red_s, green_s, blue_s},
                 underflow_s, ergb, euf); end
      if (prev_h === 1'b1 && hsync_s === 1'b0 && hfall < 0) hfall = c;
      if (prev_v === 1'b1 && vsync_s === 1'b0) begin
        if (vfall1 < 0) vfall1 = c; else if (vfall2 < 0) vfall2 = c;
      end
      if (prev_v === 1'b0 && vsync_s === 1'b1 && vrise < 0) vrise = c;
      prev_h = hsync_s;
      prev_v = vsync_s;
    end
    vec++; if (hfall != 19) begin err++;
      $display("FAIL small_hsync_fall: got %0d want 19", hfall); end
    vec++; if (vfall1 != 351) begin err++;
      $display("FAIL small_vsync_fall: got %0d want 351", vfall1); end
    vec++; if (vrise - vfall1 != 50) begin err++;
      $display("FAIL small_vsync_width: got %0d want 50", vrise - vfall1); end
    vec++; if (vfall2 - vfall1 != SFT) begin err++;
      $display("FAIL small_frame_period: got %0d want %0d", vfall2 - vfall1, SFT); end
    vec++; if (acc_f != 192 || acc_l != 16) begin err++;
      $display("FAIL small_pixel_counts: got %0d,%0d want 192,16", acc_f, acc_l); end
  endtask

  task automatic test_reset_midframe();
    bit rdy, er, ehs, evs, euf;
    logic [DW-1:0] ergb;
    logic prev;
    int fall;
    // 640x480 instance: reset in the middle of a line at pixel 300.
    while (pos % HT != 300) step_d(1'b1, 1'b0, rdy, er, ergb, ehs, evs, euf);
    vec++; if ({red, green, blue} !== ergb) begin err++;
      $display("FAIL pre_reset_rgb: got %h want %h", {red, green, blue}, ergb); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec++; if (hsync !== 1'b1 || vsync !== 1'b1 || {red, green, blue} !== '0 ||
               underflow !== 1'b0 || pix_ready !== 1'b0) begin err++;
      $display("FAIL mid_reset_now: got hs=%b vs=%b rgb=%h uf=%b rdy=%b want 1 1 0 0 0",
               hsync, vsync, {red, green, blue}, underflow, pix_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pos   = 0;
    pcnt  = 0;
    prev  = 1'b1;
    fall  = -1;
    for (int c = 1; c <= 700; c++) begin
      step_d(1'b1, 1'b0, rdy, er, ergb, ehs, evs, euf);
      vec++; if (hsync !== ehs || {red, green, blue} !== ergb) begin err++;
        $display("FAIL restart c=%0d: got %b/%h want %b/%h", c, hsync, {red, green, blue},
                 ehs, ergb); end
      if (prev === 1'b1 && hsync === 1'b0 && fall < 0) fall = c;
      prev = hsync;
    end
    vec++; if (fall != 657) begin err++;
      $display("FAIL restart_hsync_fall: got %0d want 657", fall); end
    // Small instance: reset at line 8 pixel 10, then restart from (0,0).
    while (pos_s % SFT != 8 * SHT + 10) step_s(1'b1, rdy, er, ergb, ehs, evs, euf);
    vec++; if ({red_s, green_s, blue_s} !== ergb) begin err++;
      $display("FAIL small_pre_reset_rgb: got %h want %h", {red_s, green_s, blue_s}, ergb); end
    @(negedge clk);
    rst_s_n = 1'b0;
    #1;
    vec++; if (hsync_s !== 1'b1 || vsync_s !== 1'b1 || {red_s, green_s, blue_s} !== '0 ||
               pix_ready_s !== 1'b0) begin err++;
      $display("FAIL small_mid_reset_now: got hs=%b vs=%b rgb=%h rdy=%b want 1 1 0 0",
               hsync_s, vsync_s, {red_s, green_s, blue_s}, pix_ready_s); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_s_n = 1'b1;
    pos_s   = 0;
    pcnt_s  = 0;
    prev    = 1'b1;
    fall    = -1;
    for (int c = 1; c <= 60; c++) begin
      step_s(1'b1, rdy, er, ergb, ehs, evs, euf);
      vec++; if (hsync_s !== ehs || {red_s, green_s, blue_s} !== ergb) begin err++;
        $display("FAIL small_restart c=%0d: got %b/%h want %b/%h", c, hsync_s,
                 {red_s, green_s, blue_s}, ehs, ergb); end
      if (prev === 1'b1 && hsync_s === 1'b0 && fall < 0) fall = c;
      prev = hsync_s;
    end
    vec++; if (fall != 19) begin err++;
      $display("FAIL small_restart_hsync_fall: got %0d want 19", fall); end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    bit rdy, er, ehs, evs, euf;
    logic [DW-1:0] ergb;
    int hc;
    while (pos % HT != 0) step_d(1'b1, 1'b0, rdy, er, ergb, ehs, evs, euf);
    for (int c = 0; c < HT; c++) begin
      hc = pos % HT;
      step_d(1'b1, 1'b1, rdy, er, ergb, ehs, evs, euf);
      vec++; if (rdy !== 1'b0) begin err++;
        $display("FAIL pattern_ready hc=%0d: got %b want 0", hc, rdy); end
      vec++; if ({red, green, blue} !== ergb || underflow !== 1'b0) begin err++;
        $display("FAIL pattern_pixel hc=%0d: got %h/%b want %h/0", hc, {red, green, blue},
                 underflow, ergb); end
      vec++; if (hsync !== ehs) begin err++;
        $display("FAIL pattern_hsync hc=%0d: got %b want %b", hc, hsync, ehs); end
    end
    pattern_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_hsync_timing();
    test_underflow();
    test_frame_small();
    test_reset_midframe();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

endmodule
